// File: rtl/io_sample_fifo.sv
// io_sample_fifo: synchronised input capture into a show-ahead valid/ready FIFO.
// Define OVF_COUNT_EN to add the saturating ovf_cnt_o drop counter.
module io_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din_i,
  input  logic [1:0]                 mode_i,
  input  logic                       strobe_i,
  output logic [WIDTH-1:0]           live_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
`ifdef OVF_COUNT_EN
  ,
  output logic [7:0]                 ovf_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, ev, full, empty, push, pop, drop;
  assign live_o = sync_q[SYNC_STAGES-1];
  assign count_o = cnt_q;
  assign overflow_o = ovf_q;
  assign out_valid_o = !empty;
  assign out_data_o = empty ? RESET_VAL : mem_q[rp_q];
  always_comb begin
    ev = mode_i == 2'b01 ? live_o != prev_q : mode_i == 2'b10 ? strobe_i : mode_i == 2'b11;
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    pop = !empty && out_ready_i;
    push = ev && (!full || pop);
    drop = ev && full && !pop;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = drop || (ovf_q && !clr_ovf_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= live_o;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  // Storage needs no reset: the head is masked to RESET_VAL while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= live_o;
  end
`ifdef OVF_COUNT_EN
  logic [7:0] oc_q, oc_d;
  assign ovf_cnt_o = oc_q;
  always_comb oc_d = drop ? (clr_ovf_i ? 8'd1 : oc_q + 8'(oc_q != 8'hFF)) : clr_ovf_i ? 8'd0 : oc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oc_q <= 8'd0;
    else oc_q <= oc_d;
  end
`endif
endmodule

// File: tb/tb_io_sample_fifo.sv
// tb_io_sample_fifo: table vectors plus scoreboard-checked capture sequences.
module tb_io_sample_fifo;
  logic clk = 0, rst = 1;
  logic [7:0] din = 8'h00;
  logic [1:0] mode = 2'b00;
  logic strobe = 0, out_ready = 0, clr_ovf = 0;
  logic [7:0] live, out_data;
  logic out_valid, overflow;
  logic [2:0] count;
`ifdef OVF_COUNT_EN
  logic [7:0] ovf_cnt;
`endif
  int checks = 0, errors = 0;
  logic [7:0] sb [$];
  typedef struct {logic [7:0] din; logic [7:0] live; int cnt;} vec_t;
  vec_t tv [5];
  always #5 clk = ~clk;
  io_sample_fifo dut (
    .clk(clk), .rst(rst), .din_i(din), .mode_i(mode), .strobe_i(strobe),
    .live_o(live), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .count_o(count), .overflow_o(overflow), .clr_ovf_i(clr_ovf)
`ifdef OVF_COUNT_EN
    , .ovf_cnt_o(ovf_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", n, a, e);
    end
  endtask
  task automatic drain();
    logic [7:0] e;
    out_ready = 1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      if (out_valid) begin
        e = sb.pop_front();
        chk("drain_data", out_data, e);
      end
      tick();
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_data_empty", out_data, 8'hFF);
    tick();
    chk("ready_empty_count", count, 0);
    out_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
  endtask
  initial begin
    tv[0] = '{8'h00, 8'h00, 1};
    tv[1] = '{8'h00, 8'h00, 1};
    tv[2] = '{8'h01, 8'h01, 2};
    tv[3] = '{8'h01, 8'h01, 2};
    tv[4] = '{8'h03, 8'h03, 3};
    tick();
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_live", live, 8'hFF);
    chk("rst_data", out_data, 8'hFF);
`ifdef OVF_COUNT_EN
    chk("rst_ovfcnt", ovf_cnt, 0);
`endif
    din = 8'h5A;
    tick();
    tick();
    chk("sync_latency", live, 8'h5A);
    mode = 2'b11;
    repeat (4) begin
      tick();
      sb.push_back(8'h5A);
    end
    chk("cont_full", count, 4);
    chk("cont_no_ovf", overflow, 0);
    tick();
    chk("cont_ovf", overflow, 1);
    chk("cont_full_hold", count, 4);
    mode = 2'b00;
    drain();
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_cleared", overflow, 0);
    din = 8'h10;
    repeat (3) tick();
    mode = 2'b11;
    repeat (4) begin
      tick();
      sb.push_back(8'h10);
    end
    chk("fill_full", count, 4);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] e;
      din = 8'(8'h20 + i);
      out_ready = 1;
      chk("stream_valid", out_valid, 1);
      chk("stream_count", count, 4);
      e = sb.pop_front();
      chk("stream_data", out_data, e);
      sb.push_back(i >= 2 ? 8'(8'h20 + i - 2) : 8'h10);
      tick();
    end
    chk("stream_no_ovf", overflow, 0);
    out_ready = 0;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr_drop_ovf", overflow, 1);
`ifdef OVF_COUNT_EN
    chk("clr_drop_cnt", ovf_cnt, 1);
`endif
    repeat (300) tick();
    chk("drops_count", count, 4);
`ifdef OVF_COUNT_EN
    chk("ovfcnt_sat", ovf_cnt, 255);
`endif
    mode = 2'b00;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_clr2", overflow, 0);
`ifdef OVF_COUNT_EN
    chk("ovfcnt_clr", ovf_cnt, 0);
`endif
    drain();
    do_reset();
    mode = 2'b01;
    for (int v = 0; v < 5; v++) begin
      din = tv[v].din;
      repeat (3) tick();
      chk("chg_live", live, tv[v].live);
      chk("chg_count", count, tv[v].cnt);
    end
    sb.push_back(8'h00);
    sb.push_back(8'h01);
    sb.push_back(8'h03);
    chk("chg_head", out_data, 8'h00);
    rst = 1;
    #1;
    chk("async_rst_count", count, 0);
    tick();
    rst = 0;
    mode = 2'b00;
    sb.delete();
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_live", live, 8'hFF);
    chk("midrst_data", out_data, 8'hFF);
    mode = 2'b10;
    for (int c = 0; c < 20; c++) begin
      din = 8'(c);
      strobe = (c == 10 || c == 13 || c == 14);
      if (c >= 2) chk("strobe_live", live, 8'(c - 2));
      if (strobe) sb.push_back(8'(c - 2));
      tick();
    end
    strobe = 0;
    chk("strobe_count", count, 3);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
